// File: rtl/dec_lag3_pipe.sv
// G.729 decoder adaptive-codebook lag decoder: pitch index -> T0, T0_frac.
// Subframe 0 also writes the T0_min/T0_max window to scratch memory;
// subframe 1 reads T0_min back.
// Ports: clk, reset (async, active high), start, index, pit_flag,
//   memIn -> memReadAddr, memWriteAddr, memOut, memWriteEn,
//   T0, T0_frac, done.
// Optional: DEC_LAG3_BFI_EN adds the bfi input and the old_T0 register.
module dec_lag3_pipe #(
  parameter int          PIT_MIN     = 20,
  parameter int          PIT_MAX     = 143,
  parameter logic [11:0] T0_MIN_ADDR = 12'd0,
  parameter logic [11:0] T0_MAX_ADDR = 12'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] index,
  input  logic [15:0] pit_flag,
`ifdef DEC_LAG3_BFI_EN
  input  logic        bfi,
`endif
  input  logic [31:0] memIn,
  output logic [11:0] memReadAddr,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic [15:0] T0,
  output logic [15:0] T0_frac,
  output logic        done
);

  localparam logic [15:0] PMIN = 16'(PIT_MIN);
  localparam logic [15:0] PMAX = 16'(PIT_MAX);

  typedef enum logic [3:0] {
    IDLE, RD_MIN, RD_WAIT, DIV, LAG,
    CLAMP, WR_MIN, WR_MAX, DONE
  } state_t;

  state_t state, nxt;

  logic [15:0] idx, quot, t0Min;
  logic [15:0] t0Calc, fracCalc;
  logic [15:0] winMin, winMax;
  logic        sub1, skipWin;
  logic [15:0] lagT0, lagFrac, iVal;
  logic [15:0] loVal, clampMin, clampMax;

`ifdef DEC_LAG3_BFI_EN
  logic        bfiR;
  logic [15:0] oldT0;
  assign skipWin = sub1 | bfiR;
`else
  assign skipWin = sub1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt          = state;
    memReadAddr  = 12'd0;
    memWriteAddr = 12'd0;
    memOut       = 32'd0;
    memWriteEn   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DEC_LAG3_BFI_EN
          if (bfi) nxt = LAG;
          else
`endif
          if (pit_flag != 16'd0) nxt = RD_MIN;
          else                   nxt = DIV;
        end
      end
      RD_MIN: begin
        memReadAddr = T0_MIN_ADDR;
        nxt         = RD_WAIT;
      end
      RD_WAIT: begin
        memReadAddr = T0_MIN_ADDR;
        nxt         = DIV;
      end
      DIV:   nxt = LAG;
      LAG:   nxt = skipWin ? DONE : CLAMP;
      CLAMP: nxt = WR_MIN;
      WR_MIN: begin
        memWriteEn   = 1'b1;
        memWriteAddr = T0_MIN_ADDR;
        memOut       = {16'h0000, winMin};
        nxt          = WR_MAX;
      end
      WR_MAX: begin
        memWriteEn   = 1'b1;
        memWriteAddr = T0_MAX_ADDR;
        memOut       = {16'h0000, winMax};
        nxt          = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Lag reconstruction from the registered quotient q = (idx+2)/3.
  always_comb begin
    iVal    = quot - 16'd1;
    lagT0   = 16'd0;
    lagFrac = 16'd0;
    if (sub1) begin
      lagT0   = t0Min + iVal;
      lagFrac = idx - 16'd2 - 16'd3 * iVal;
    end else if (idx < 16'd197) begin
      lagT0   = quot + 16'd19;
      lagFrac = idx - 16'd3 * (quot + 16'd19) + 16'd58;
    end else begin
      lagT0   = idx - 16'd112;
      lagFrac = 16'd0;
    end
`ifdef DEC_LAG3_BFI_EN
    if (bfiR) begin
      lagT0   = oldT0;
      lagFrac = 16'd0;
    end
`endif
  end

  always_comb begin
    loVal    = t0Calc - 16'd5;
    clampMin = ($signed(loVal) < $signed(PMIN)) ? PMIN : loVal;
    clampMax = clampMin + 16'd9;
    if ($signed(clampMax) > $signed(PMAX)) begin
      clampMax = PMAX;
      clampMin = PMAX - 16'd9;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= 16'd0;
      sub1     <= 1'b0;
      quot     <= 16'd0;
      t0Min    <= 16'd0;
      t0Calc   <= 16'd0;
      fracCalc <= 16'd0;
      winMin   <= 16'd0;
      winMax   <= 16'd0;
      T0       <= 16'd0;
      T0_frac  <= 16'd0;
      done     <= 1'b0;
`ifdef DEC_LAG3_BFI_EN
      bfiR     <= 1'b0;
      oldT0    <= 16'd60;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subframe 0 carries 8 index bits, subframe 1 only 5.
            idx  <= (pit_flag == 16'd0) ? (index & 16'h00FF)
                                        : (index & 16'h001F);
            sub1 <= (pit_flag != 16'd0);
            done <= 1'b0;
`ifdef DEC_LAG3_BFI_EN
            bfiR <= bfi;
`endif
          end
        end
        RD_WAIT: t0Min <= 16'(memIn);
        // 10923/32768 ~ 1/3, exact over the legal index range.
        DIV: quot <= 16'((({16'h0000, idx} + 32'd2) * 32'd10923) >> 15);
        LAG: begin
          t0Calc   <= lagT0;
          fracCalc <= lagFrac;
`ifdef DEC_LAG3_BFI_EN
          if (bfiR)
            oldT0 <= (oldT0 >= PMAX) ? PMAX : oldT0 + 16'd1;
          else if (!sub1)
            oldT0 <= lagT0;
`endif
        end
        CLAMP: begin
          winMin <= clampMin;
          winMax <= clampMax;
        end
        DONE: begin
          T0      <= t0Calc;
          T0_frac <= fracCalc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_lag3_pipe.sv
// Self-checking bench for dec_lag3_pipe: directed spec vectors plus
// randomized subframe pairs against an arithmetic reference model.
module tb_dec_lag3_pipe;

  localparam logic [11:0] AMIN = 12'h020;
  localparam logic [11:0] AMAX = 12'h021;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] index = 16'd0;
  logic [15:0] pit_flag = 16'd0;
  logic [31:0] memIn = 32'd0;
  logic [11:0] memReadAddr, memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn;
  logic [15:0] T0, T0_frac;
  logic        done;
`ifdef DEC_LAG3_BFI_EN
  logic        bfi = 1'b0;
`endif

  logic [31:0] mem [4096];
  int wrCount = 0;
  int compared = 0;
  int mismatched = 0;

  dec_lag3_pipe #(
    .T0_MIN_ADDR(AMIN),
    .T0_MAX_ADDR(AMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .index(index),
    .pit_flag(pit_flag),
`ifdef DEC_LAG3_BFI_EN
    .bfi(bfi),
`endif
    .memIn(memIn),
    .memReadAddr(memReadAddr),
    .memWriteAddr(memWriteAddr),
    .memOut(memOut),
    .memWriteEn(memWriteEn),
    .T0(T0),
    .T0_frac(T0_frac),
    .done(done)
  );

  always #5 clk = ~clk;

  // Scratch memory: one-cycle read latency, synchronous write.
  always @(posedge clk) begin
    memIn <= mem[memReadAddr];
    if (memWriteEn) begin
      mem[memWriteAddr] <= memOut;
      wrCount <= wrCount + 1;
    end
  end

  // Reference: division by 3 done with plain integer arithmetic.
  function automatic void model0(input int ix, output int t0,
                                 output int fr, output int mn,
                                 output int mx);
    if (ix < 197) begin
      t0 = (ix + 2) / 3 + 19;
      fr = ix - 3 * t0 + 58;
    end else begin
      t0 = ix - 112;
      fr = 0;
    end
    mn = (t0 - 5 < 20) ? 20 : t0 - 5;
    mx = mn + 9;
    if (mx > 143) begin
      mx = 143;
      mn = 134;
    end
  endfunction

  function automatic void model1(input int ix, input int mn,
                                 output int t0, output int fr);
    int i;
    i  = (ix + 2) / 3 - 1;
    t0 = mn + i;
    fr = ix - 2 - 3 * i;
  endfunction

  // Issue one request and count edges after the sample edge until done.
  task automatic run_op(input logic [15:0] pf, input logic [15:0] ix,
                        output int edges);
    @(negedge clk);
    pit_flag = pf;
    index    = ix;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    pit_flag = 16'($urandom);
    index    = 16'($urandom);
    edges    = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if ({T0, T0_frac, done} !== 33'd0) begin
      mismatched++;
      $display("FAIL reset_out: got T0=%0d frac=%0d done=%0b want 0",
               T0, T0_frac, done);
    end
    compared++;
    if ({memReadAddr, memWriteAddr, memOut, memWriteEn} !== 57'd0) begin
      mismatched++;
      $display("FAIL reset_mem: got ra=%0h wa=%0h d=%0h we=%0b want 0",
               memReadAddr, memWriteAddr, memOut, memWriteEn);
    end
    reset = 1'b0;
  endtask

  task automatic test_sub0();
    int ix [4] = '{0, 100, 255, 197};
    int et [4] = '{19, 53, 143, 85};
    int ef [4] = '{1, -1, 0, 0};
    int en [4] = '{20, 48, 134, 80};
    int ex [4] = '{29, 57, 143, 89};
    int edges, w0;
    for (int k = 0; k < 4; k++) begin
      w0 = wrCount;
      run_op(16'd0, 16'(ix[k]), edges);
      compared++;
      if (edges !== 6) begin
        mismatched++;
        $display("FAIL sub0_lat[%0d]: got %0d want 6", ix[k], edges);
      end
      compared++;
      if (T0 !== 16'(et[k]) || T0_frac !== 16'(ef[k])) begin
        mismatched++;
        $display("FAIL sub0_lag[%0d]: got %0d/%0d want %0d/%0d",
                 ix[k], $signed(T0), $signed(T0_frac), et[k], ef[k]);
      end
      compared++;
      if (mem[AMIN] !== {16'h0, 16'(en[k])} ||
          mem[AMAX] !== {16'h0, 16'(ex[k])} || wrCount - w0 != 2) begin
        mismatched++;
        $display("FAIL sub0_win[%0d]: got %0h/%0h w=%0d want %0d/%0d w=2",
                 ix[k], mem[AMIN], mem[AMAX], wrCount - w0, en[k], ex[k]);
      end
    end
  endtask

  task automatic test_sub1();
    int ix [2] = '{17, 0};
    int et [2] = '{53, 47};
    int ef [2] = '{0, 1};
    int edges, w0;
    run_op(16'd0, 16'd100, edges);
    for (int k = 0; k < 2; k++) begin
      w0 = wrCount;
      run_op(16'd1, 16'(ix[k]), edges);
      compared++;
      if (edges !== 5 || wrCount != w0) begin
        mismatched++;
        $display("FAIL sub1_lat[%0d]: got %0d w=%0d want 5 w=0",
                 ix[k], edges, wrCount - w0);
      end
      compared++;
      if (T0 !== 16'(et[k]) || T0_frac !== 16'(ef[k])) begin
        mismatched++;
        $display("FAIL sub1_lag[%0d]: got %0d/%0d want %0d/%0d",
                 ix[k], $signed(T0), $signed(T0_frac), et[k], ef[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] raw;
    int ix, t0, fr, mn, mx, edges, w0;
    for (int k = 0; k < 40; k++) begin
      raw = 16'($urandom);
      ix  = int'(raw[7:0]);
      model0(ix, t0, fr, mn, mx);
      w0 = wrCount;
      run_op(16'd0, raw, edges);
      compared++;
      if (edges !== 6 || T0 !== 16'(t0) || T0_frac !== 16'(fr)) begin
        mismatched++;
        $display("FAIL rnd0[%0d]: got %0d/%0d e=%0d want %0d/%0d e=6",
                 ix, $signed(T0), $signed(T0_frac), edges, t0, fr);
      end
      compared++;
      if (mem[AMIN] !== {16'h0, 16'(mn)} ||
          mem[AMAX] !== {16'h0, 16'(mx)} || wrCount - w0 != 2) begin
        mismatched++;
        $display("FAIL rnd0_win[%0d]: got %0h/%0h want %0d/%0d",
                 ix, mem[AMIN], mem[AMAX], mn, mx);
      end
      raw = 16'($urandom);
      ix  = int'(raw[4:0]);
      model1(ix, mn, t0, fr);
      w0 = wrCount;
      run_op(16'($urandom_range(1, 65535)), raw, edges);
      compared++;
      if (edges !== 5 || T0 !== 16'(t0) || T0_frac !== 16'(fr) ||
          wrCount != w0) begin
        mismatched++;
        $display("FAIL rnd1[%0d]: got %0d/%0d e=%0d want %0d/%0d e=5",
                 ix, $signed(T0), $signed(T0_frac), edges, t0, fr);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] a0, a1;
    int w0, edges;
    logic seen;
    a0 = mem[AMIN];
    a1 = mem[AMAX];
    @(negedge clk);
    pit_flag = 16'd0;
    index    = 16'd50;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (memWriteEn) begin
        seen = 1'b1;
        break;
      end
    end
    w0 = wrCount;
    reset = 1'b1;
    #1;
    compared++;
    if (!seen || {T0, T0_frac, done, memWriteEn, memOut} !== 66'd0) begin
      mismatched++;
      $display("FAIL abort_out: seen=%0b T0=%0d we=%0b d=%0h want 0",
               seen, T0, memWriteEn, memOut);
    end
    @(posedge clk);
    #1;
    compared++;
    if (mem[AMIN] !== a0 || mem[AMAX] !== a1 || wrCount != w0) begin
      mismatched++;
      $display("FAIL abort_mem: got %0h/%0h want %0h/%0h",
               mem[AMIN], mem[AMAX], a0, a1);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(16'd0, 16'd0, edges);
    compared++;
    if (edges !== 6 || T0 !== 16'd19 || T0_frac !== 16'd1 ||
        mem[AMIN] !== 32'd20 || mem[AMAX] !== 32'd29) begin
      mismatched++;
      $display("FAIL abort_resume: got %0d/%0d e=%0d want 19/1 e=6",
               T0, T0_frac, edges);
    end
  endtask

  task automatic test_busy_start();
    int w0, edges, drops;
    w0 = wrCount;
    @(negedge clk);
    pit_flag = 16'd0;
    index    = 16'd100;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = -1;
    for (int n = 1; n <= 20; n++) begin
      if (n == 2 || n == 4) begin
        pit_flag = 16'd1;
        index    = 16'd0;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        break;
      end
    end
    start = 1'b0;
    compared++;
    if (edges !== 6 || T0 !== 16'd53 || T0_frac !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL busy_lag: got %0d/%0d e=%0d want 53/-1 e=6",
               $signed(T0), $signed(T0_frac), edges);
    end
    drops = 0;
    repeat (10) begin
      @(negedge clk);
      if (!done || T0 !== 16'd53) drops++;
    end
    compared++;
    if (drops != 0 || wrCount - w0 != 2) begin
      mismatched++;
      $display("FAIL busy_hold: got drops=%0d w=%0d want 0 w=2",
               drops, wrCount - w0);
    end
  endtask

`ifdef DEC_LAG3_BFI_EN
  task automatic test_bfi();
    int edges, w0;
    int ep [4] = '{53, 54, 143, 143};
    run_op(16'd0, 16'd100, edges);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) run_op(16'd0, 16'd255, edges);
      w0  = wrCount;
      bfi = 1'b1;
      run_op(16'(k & 1), 16'd7, edges);
      bfi = 1'b0;
      compared++;
      if (edges !== 2 || T0 !== 16'(ep[k]) || T0_frac !== 16'd0 ||
          wrCount != w0) begin
        mismatched++;
        $display("FAIL bfi[%0d]: got %0d/%0d e=%0d want %0d/0 e=2",
                 k, T0, T0_frac, edges, ep[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sub0();
    test_sub1();
    test_random();
    test_abort();
    test_busy_start();
`ifdef DEC_LAG3_BFI_EN
    test_bfi();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
